l80_rx_fifo: RTL

Receive buffer between the UART receiver and the light8080 I/O space. Bytes from the receiver are queued in a small FIFO so that bursts arriving while the CPU is busy are not lost. The CPU reads the queue and a status byte through port-mapped registers. A level interrupt request is raised while data is pending. The block replaces the single-byte rxfull/rxData path in the SoC and drives the io_dout read mux directly.

---
 rtl/l80_rx_fifo_if.sv | 32 +++
 rtl/l80_rx_fifo.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/l80_rx_fifo_if.sv
// ---------------------------------------------------------------------------
// l80_rx_fifo_if
//   Bundle of the receive-FIFO data, CPU I/O and status signals.
//   master : UART receiver / CPU side (drives rx_byte, rx_valid, cpu_io,
//            cpu_rd, cpu_addr, tx_busy; observes io_dout, rx_nempty,
//            rx_overrun, fifo_count)
//   slave  : the FIFO block itself
// ---------------------------------------------------------------------------
interface l80_rx_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic [7:0]          rx_byte;
    logic                rx_valid;
    logic                cpu_io;
    logic                cpu_rd;
    logic [7:0]          cpu_addr;
    logic                tx_busy;
    logic [7:0]          io_dout;
    logic                rx_nempty;
    logic                rx_overrun;
    logic [DEPTH_LOG2:0] fifo_count;

    modport master (
        output rx_byte, rx_valid, cpu_io, cpu_rd, cpu_addr, tx_busy,
        input  io_dout, rx_nempty, rx_overrun, fifo_count
    );

    modport slave (
        input  rx_byte, rx_valid, cpu_io, cpu_rd, cpu_addr, tx_busy,
        output io_dout, rx_nempty, rx_overrun, fifo_count
    );
endinterface

// File: rtl/l80_rx_fifo.sv
// ---------------------------------------------------------------------------
// l80_rx_fifo
//   Receive byte queue between the UART receiver and the light8080 I/O space.
//   Bytes pushed by the receiver are buffered; the CPU pops them by reading
//   DATA_ADDR and reads a status byte at STAT_ADDR. rx_nempty doubles as the
//   level interrupt request.
//
//   Ports:
//     clock   - block clock, rising edge
//     reset2  - asynchronous active-high reset
//     bus     - l80_rx_fifo_if.slave:
//                 rx_byte/rx_valid    receiver push
//                 cpu_io/cpu_rd/cpu_addr  CPU I/O read access
//                 tx_busy             reported in status bit 0
//                 io_dout             registered read data
//                 rx_nempty           FIFO not empty (IRQ level)
//                 rx_overrun          sticky dropped-byte flag
//                 fifo_count          number of stored bytes
//
//   Status byte: {3'b0, rx_nempty, rx_overrun, full, 1'b0, tx_busy}
// ---------------------------------------------------------------------------
module l80_rx_fifo #(
    parameter int         DEPTH_LOG2 = 4,
    parameter logic [7:0] DATA_ADDR  = 8'h80,
    parameter logic [7:0] STAT_ADDR  = 8'h83
) (
    input logic          clock,
    input logic          reset2,
    l80_rx_fifo_if.slave bus
);

    localparam int                  DEPTH     = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] COUNT_MAX = DEPTH[DEPTH_LOG2:0];

    // Storage has no reset; contents are don't-care until written.
    logic [7:0]            mem [DEPTH];

    logic [DEPTH_LOG2-1:0] wp_reg;
    logic [DEPTH_LOG2-1:0] rp_reg;
    logic [DEPTH_LOG2:0]   count_reg;
    logic [DEPTH_LOG2:0]   count_next;
    logic                  overrun_reg;
    logic                  overrun_next;
    logic                  nempty_reg;
    logic [7:0]            dout_reg;
    logic [7:0]            dout_next;
    logic                  rd_hit_d_reg;
    logic                  st_hit_d_reg;

    logic                  full;
    logic                  empty;
    logic                  rd_hit;
    logic                  st_hit;
    logic                  pop;
    logic                  push;
    logic                  overrun_set;
    logic                  status_clear;
    logic [7:0]            status_byte;

    assign full  = (count_reg == COUNT_MAX);
    assign empty = (count_reg == '0);

    assign rd_hit = bus.cpu_io & bus.cpu_rd & (bus.cpu_addr == DATA_ADDR);
    assign st_hit = bus.cpu_io & bus.cpu_rd & (bus.cpu_addr == STAT_ADDR);

    // Edge detection so a read strobe held for several cycles acts once.
    assign pop          = rd_hit & ~rd_hit_d_reg & ~empty;
    assign status_clear = st_hit & ~st_hit_d_reg;

    // A pop in the same cycle frees the slot the push needs, even when full.
    assign push        = bus.rx_valid & (~full | pop);
    assign overrun_set = bus.rx_valid & full & ~pop;

    assign status_byte = {3'b000, nempty_reg, overrun_reg, full, 1'b0, bus.tx_busy};

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Set beats clear when both happen in one cycle.
    always_comb begin
        overrun_next = overrun_reg;
        if (overrun_set) begin
            overrun_next = 1'b1;
        end else if (status_clear) begin
            overrun_next = 1'b0;
        end
    end

    // Read mux is sampled from pre-update state, so a popping read returns
    // the byte being removed.
    always_comb begin
        dout_next = dout_reg;
        if (bus.cpu_io) begin
            if (bus.cpu_addr == DATA_ADDR) begin
                dout_next = empty ? 8'h00 : mem[rp_reg];
            end else if (bus.cpu_addr == STAT_ADDR) begin
                dout_next = status_byte;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wp_reg] <= bus.rx_byte;
        end
    end

    always_ff @(posedge clock or posedge reset2) begin
        if (reset2) begin
            wp_reg       <= '0;
            rp_reg       <= '0;
            count_reg    <= '0;
            overrun_reg  <= 1'b0;
            nempty_reg   <= 1'b0;
            dout_reg     <= 8'h00;
            rd_hit_d_reg <= 1'b0;
            st_hit_d_reg <= 1'b0;
        end else begin
            if (push) begin
                wp_reg <= wp_reg + 1'b1;
            end
            if (pop) begin
                rp_reg <= rp_reg + 1'b1;
            end
            count_reg    <= count_next;
            overrun_reg  <= overrun_next;
            nempty_reg   <= (count_next != '0);
            dout_reg     <= dout_next;
            rd_hit_d_reg <= rd_hit;
            st_hit_d_reg <= st_hit;
        end
    end

    assign bus.io_dout    = dout_reg;
    assign bus.rx_nempty  = nempty_reg;
    assign bus.rx_overrun = overrun_reg;
    assign bus.fifo_count = count_reg;

endmodule
